// File: rtl/fp_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : fp_seq_multiplier
//  Description : Iterative floating-point multiplier. Radix-2 shift-add
//                mantissa product, nearest-even rounding, valid/ready I/O.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_seq_multiplier #(
  parameter int EB = 8,
  parameter int MB = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EB+MB:0]    fp_multiplicand,
  input  logic [EB+MB:0]    fp_multiplier,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EB+MB:0]    fp_product,
  output logic              ovf,
  output logic              unf,
  output logic              nv
);

  localparam int N    = EB + MB + 1;
  localparam int BIAS = 2**(EB-1) - 1;
  localparam int PW   = 2*MB + 2;
  localparam int CW   = $clog2(MB + 2);

  localparam logic signed [EB+1:0] c_bias    = (EB+2)'(BIAS);
  localparam logic signed [EB+1:0] c_exp_max = (EB+2)'(2**EB - 1);
  localparam logic signed [EB+1:0] c_exp_one = (EB+2)'(1);
  localparam logic [N-1:0]         c_nan     = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;

  logic                  r_sign;
  logic signed [EB+1:0]  r_exp;
  logic [PW-1:0]         r_mcand;
  logic [MB:0]           r_mplier;
  logic [PW-1:0]         r_acc;
  logic [CW-1:0]         r_cnt;
  logic [N-1:0]          r_product;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  r_nv;

  // Operand classification; denormals count as zero (flush-to-zero)
  logic                  w_sa, w_sb, w_sign;
  logic [EB-1:0]         w_ea, w_eb;
  logic [MB-1:0]         w_ma, w_mb;
  logic                  w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic                  w_nan, w_inf, w_zero, w_special;
  logic [N-1:0]          w_special_result;
  logic signed [EB+1:0]  w_exp_sum;

  assign w_sa     = fp_multiplicand[N-1];
  assign w_sb     = fp_multiplier[N-1];
  assign w_ea     = fp_multiplicand[N-2:MB];
  assign w_eb     = fp_multiplier[N-2:MB];
  assign w_ma     = fp_multiplicand[MB-1:0];
  assign w_mb     = fp_multiplier[MB-1:0];
  assign w_sign   = w_sa ^ w_sb;

  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == '1) && (w_ma == '0);
  assign w_b_inf  = (w_eb == '1) && (w_mb == '0);
  assign w_a_nan  = (w_ea == '1) && (w_ma != '0);
  assign w_b_nan  = (w_eb == '1) && (w_mb != '0);

  assign w_nan     = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
  assign w_inf     = w_a_inf | w_b_inf;
  assign w_zero    = w_a_zero | w_b_zero;
  assign w_special = w_nan | w_inf | w_zero;

  assign w_special_result = w_nan ? c_nan :
                            w_inf ? {w_sign, {EB{1'b1}}, {MB{1'b0}}} :
                                    {w_sign, {(N-1){1'b0}}};

  assign w_exp_sum = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - c_bias;

  // Normalization and round-to-nearest-even of the accumulated product
  logic                  w_hi;
  logic [MB-1:0]         w_mant_pre;
  logic                  w_guard, w_sticky, w_rnd_up;
  logic [MB:0]           w_mant_rnd;
  logic [EB+1:0]         w_exp_inc;
  logic signed [EB+1:0]  w_exp_fin;

  assign w_hi       = r_acc[PW-1];
  assign w_mant_pre = w_hi ? r_acc[PW-2:MB+1] : r_acc[PW-3:MB];
  assign w_guard    = w_hi ? r_acc[MB] : r_acc[MB-1];
  assign w_sticky   = w_hi ? (|r_acc[MB-1:0]) : (|r_acc[MB-2:0]);
  assign w_rnd_up   = w_guard & (w_sticky | w_mant_pre[0]);
  assign w_mant_rnd = {1'b0, w_mant_pre} + {{MB{1'b0}}, w_rnd_up};
  assign w_exp_inc  = {{(EB+1){1'b0}}, w_hi} + {{(EB+1){1'b0}}, w_mant_rnd[MB]};
  assign w_exp_fin  = r_exp + $signed(w_exp_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = w_special ? DONE : MUL;
      MUL:     if (r_cnt == CW'(MB)) w_state_next = NORM;
      NORM:    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_nv      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign   <= w_sign;
            r_exp    <= w_exp_sum;
            r_mcand  <= {{(MB+1){1'b0}}, 1'b1, w_ma};
            r_mplier <= {1'b1, w_mb};
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_nv     <= w_nan;
            if (w_special) r_product <= w_special_result;
          end
        end
        MUL: begin
          // LSB-first: the multiplicand shifts left as multiplier bits retire
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        NORM: begin
          if (w_exp_fin >= c_exp_max) begin
            r_product <= {r_sign, {EB{1'b1}}, {MB{1'b0}}};
            r_ovf     <= 1'b1;
          end else if (w_exp_fin < c_exp_one) begin
            r_product <= {r_sign, {(N-1){1'b0}}};
            r_unf     <= 1'b1;
          end else begin
            r_product <= {r_sign, w_exp_fin[EB-1:0], w_mant_rnd[MB-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign fp_product = r_product;
  assign ovf        = r_ovf;
  assign unf        = r_unf;
  assign nv         = r_nv;

endmodule
`default_nettype wire
